uart_rx_byte: RTL and testbench

- Serial receiver that sits directly upstream of the serial command processor.
- Converts the asynchronous RS232 line (8N1, LSB first) into parallel bytes.
- Delivers each byte on RX with a one-cycle RX_ready strobe, matching the processor's RX/RX_ready inputs.
- Adds metastability hardening, start-bit glitch rejection and framing-error reporting.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_byte.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART blocks.
//   UartRxState          - receiver FSM state, 3-bit encoding (6 and 7 are illegal)
//   UART_DATA_BITS       - data bits per frame
//   UART_CLKS_PER_BIT    - default bit period in clk cycles (50 MHz / 115200),
//                          shared with the transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } UartRxState;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep flop chain that brings an asynchronous input into
// the clk domain. The reset value is a parameter so that idle-high lines (UART)
// and idle-low inputs (buttons) both come out of reset in their idle level.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset (chain loads RESET_VAL)
//   d    - asynchronous input
//   q    - synchronized output, lags d by STAGES cycles
module uart_rx_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chainReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chainReg <= {STAGES{RESET_VAL}};
    end else begin
      chainReg <= {chainReg[STAGES-2:0], d};
    end
  end

  assign q = chainReg[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: RS232 receiver (8N1, LSB first) feeding the command processor.
// Samples each bit at mid-period on the synchronized line, rejects short
// start-bit glitches, and reports a low stop bit as a framing error.
// Ports:
//   clk           - system clock
//   rst           - asynchronous, active-high reset
//   rx_serial     - raw serial line, idle high
//   RX            - last correctly received byte
//   RX_ready      - one-cycle strobe, RX holds a new byte
//   framing_error - one-cycle strobe, stop bit sampled low
//   busy          - high whenever the FSM is not in IDLE
//   parity_error  - (UART_RX_PARITY_EN only) one-cycle strobe, parity mismatch
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 frames (PARITY_ODD
// selects odd parity); undefined gives plain 8N1.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  , parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_serial,
  output logic [UART_DATA_BITS-1:0] RX,
  output logic                      RX_ready,
  output logic                      framing_error,
  output logic                      busy
`ifdef UART_RX_PARITY_EN
  , output logic                    parity_error
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic rxs;

  uart_rx_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) rxSync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  UartRxState                stateReg,    stateNext;
  logic [CW-1:0]             cycleReg,    cycleNext;
  logic [2:0]                bitIdxReg,   bitIdxNext;
  logic [UART_DATA_BITS-1:0] shiftReg,    shiftNext;
  logic [UART_DATA_BITS-1:0] rxReg,       rxNext;
  logic                      readyReg,    readyNext;
  logic                      framingReg,  framingNext;
`ifdef UART_RX_PARITY_EN
  logic                      parityBitReg, parityBitNext;
  logic                      parityErrReg, parityErrNext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      cycleReg   <= '0;
      bitIdxReg  <= '0;
      shiftReg   <= '0;
      rxReg      <= '0;
      readyReg   <= 1'b0;
      framingReg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBitReg <= 1'b0;
      parityErrReg <= 1'b0;
`endif
    end else begin
      stateReg   <= stateNext;
      cycleReg   <= cycleNext;
      bitIdxReg  <= bitIdxNext;
      shiftReg   <= shiftNext;
      rxReg      <= rxNext;
      readyReg   <= readyNext;
      framingReg <= framingNext;
`ifdef UART_RX_PARITY_EN
      parityBitReg <= parityBitNext;
      parityErrReg <= parityErrNext;
`endif
    end
  end

  always_comb begin
    stateNext   = stateReg;
    cycleNext   = cycleReg + CW'(1);
    bitIdxNext  = bitIdxReg;
    shiftNext   = shiftReg;
    rxNext      = rxReg;
    readyNext   = 1'b0;
    framingNext = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBitNext = parityBitReg;
    parityErrNext = 1'b0;
`endif
    case (stateReg)
      IDLE: begin
        cycleNext = '0;
        if (!rxs) stateNext = START;
      end
      START: begin
        // Re-check the line half a bit after the falling edge; a line that is
        // already high again was a glitch, not a start bit.
        if (cycleReg == HALF_CNT) begin
          cycleNext  = '0;
          bitIdxNext = '0;
          stateNext  = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cycleReg == LAST_CNT) begin
          cycleNext            = '0;
          shiftNext[bitIdxReg] = rxs;
          bitIdxNext           = bitIdxReg + 3'd1;
          if (bitIdxReg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cycleReg == LAST_CNT) begin
          cycleNext     = '0;
          parityBitNext = rxs;
          stateNext     = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a start bit
        // that follows with no idle gap.
        if (cycleReg == LAST_CNT) begin
          cycleNext = '0;
          if (rxs) begin
            stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shiftReg ^ parityBitReg) != PARITY_ODD) begin
              parityErrNext = 1'b1;
            end else begin
              rxNext    = shiftReg;
              readyNext = 1'b1;
            end
`else
            rxNext    = shiftReg;
            readyNext = 1'b1;
`endif
          end else begin
            framingNext = 1'b1;
            stateNext   = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold here until the line idles so a long break reports only once.
        cycleNext = '0;
        if (rxs) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cycleNext = '0;
      end
    endcase
  end

  assign RX            = rxReg;
  assign RX_ready      = readyReg;
  assign framing_error = framingReg;
  assign busy          = (stateReg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parityErrReg;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte with CLKS_PER_BIT=8, SYNC_STAGES=2. Stimulus tasks
// push the expected strobe (kind + RX value) into a queue; the monitor pops and
// compares whenever RX_ready, framing_error or parity_error fires.
module tb_uart_rx_byte;

  localparam int CPB = 8;

  typedef struct {
    int         kind;   // 0 = RX_ready, 1 = framing_error, 2 = parity_error
    logic [7:0] data;   // RX value expected while the strobe is high
  } ExpEvent;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxSerial = 1'b1;
  logic [7:0] RX;
  logic       RX_ready;
  logic       framing_error;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parityError;
  logic       flipParity = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int readyTimes[$];
  ExpEvent expQ[$];
  logic prevReady = 1'b0;
  logic prevFerr = 1'b0;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD (1'b0)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_serial     (rxSerial),
    .RX            (RX),
    .RX_ready      (RX_ready),
    .framing_error (framing_error),
    .busy          (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_error (parityError)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectEv(input int kind, input logic [7:0] data);
    ExpEvent e;
    e.kind = kind;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Holds one bit level for a full bit period; returns at posedge+1.
  task automatic driveBit(input logic b);
    rxSerial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(^d ^ flipParity);
`endif
    driveBit(stopBit);
  endtask

  task automatic idle(input int n);
    rxSerial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rxSerial = 1'b1;
    rst = 1'b1;
    #1;
    check("reset_RX", RX, 8'h00);
    check("reset_RX_ready", RX_ready, 1'b0);
    check("reset_framing_error", framing_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ExpEvent e;
    int kind;
    kind = -1;
    if (rst) begin
      prevReady = 1'b0;
      prevFerr  = 1'b0;
    end else begin
      if (RX_ready && framing_error) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap: RX_ready=%0b framing_error=%0b, required not both", RX_ready, framing_error);
      end
      if (RX_ready) begin
        kind = 0;
        readyTimes.push_back(cycleCount);
        check("ready_width", prevReady, 1'b0);
      end
      if (framing_error) begin
        kind = 1;
        check("ferr_width", prevFerr, 1'b0);
      end
`ifdef UART_RX_PARITY_EN
      if (parityError) begin
        kind = 2;
        check("perr_overlap", RX_ready | framing_error, 1'b0);
      end
`endif
      if (kind >= 0) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: kind %0d RX 0x%02h, required no strobe", kind, RX);
        end else begin
          e = expQ.pop_front();
          if (e.kind != kind || e.data !== RX) begin
            errors++;
            $display("FAIL strobe: got kind %0d RX 0x%02h, expected kind %0d RX 0x%02h", kind, RX, e.kind, e.data);
          end else begin
            $display("strobe kind %0d RX 0x%02h ok at cycle %0d", kind, RX, cycleCount);
          end
        end
      end
      prevReady = RX_ready;
      prevFerr  = framing_error;
    end
  end

  initial begin
    doReset();

    // Plain frame.
    expectEv(0, 8'h55);
    sendFrame(8'h55, 1'b1);
    idle(20);
    check("rx_55", RX, 8'h55);

    // 3-cycle glitch: START is entered 3 cycles after the drop and abandoned
    // 4 cycles later, with no strobe.
    rxSerial = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxSerial = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("glitch_busy_high", busy, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_low", busy, 1'b0);
    @(posedge clk);
    #1;
    idle(10);
    expectEv(0, 8'hA3);
    sendFrame(8'hA3, 1'b1);
    idle(20);
    check("rx_a3", RX, 8'hA3);

    // Framing error followed by a held break, then a good frame.
    doReset();
    expectEv(1, 8'h00);
    sendFrame(8'h3C, 1'b0);
    rxSerial = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(16);
    check("rx_after_break", RX, 8'h00);
    expectEv(0, 8'h81);
    sendFrame(8'h81, 1'b1);
    idle(20);
    check("rx_81", RX, 8'h81);

    // Back-to-back frames, no idle gap.
    readyTimes.delete();
    expectEv(0, 8'h0A);
    expectEv(0, 8'h5A);
    expectEv(0, 8'h49);
    expectEv(0, 8'h50);
    sendFrame(8'h0A, 1'b1);
    sendFrame(8'h5A, 1'b1);
    sendFrame(8'h49, 1'b1);
    sendFrame(8'h50, 1'b1);
    idle(20);
    check("b2b_count", readyTimes.size(), 4);
    for (int i = 1; i < readyTimes.size(); i++) begin
      check("b2b_spacing", readyTimes[i] - readyTimes[i-1], 80);
    end

    // Reset during bit 4 of 0xFF.
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rxSerial = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_RX", RX, 8'h00);
    check("midrst_RX_ready", RX_ready, 1'b0);
    check("midrst_framing_error", framing_error, 1'b0);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    expectEv(0, 8'h12);
    sendFrame(8'h12, 1'b1);
    idle(20);
    check("rx_12", RX, 8'h12);

`ifdef UART_RX_PARITY_EN
    expectEv(0, 8'h07);
    sendFrame(8'h07, 1'b1);
    flipParity = 1'b1;
    expectEv(2, 8'h07);
    sendFrame(8'h07, 1'b1);
    flipParity = 1'b0;
    idle(20);
    check("rx_07_after_perr", RX, 8'h07);
`endif

    check("events_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
